// File: rtl/vga_pkg.sv
// Shared screen geometry, pixel types and the on-screen test for the
// VGA plot path (160x120 display, 3-bit colour).
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [2:0] colour_t;
  typedef logic [7:0] scr_x_t;
  typedef logic [6:0] scr_y_t;

  typedef struct packed {
    scr_x_t  x;
    scr_y_t  y;
    colour_t c;
  } pixel_t;

  // Engines emit signed, unclipped points; widen to int so the compare is signed.
  function automatic logic on_screen(input logic signed [8:0] x,
                                     input logic signed [7:0] y);
    int sx;
    int sy;
    sx = int'(x);
    sy = int'(y);
    return (sx >= 0) && (sx < SCREEN_W) && (sy >= 0) && (sy < SCREEN_H);
  endfunction

endpackage

// File: rtl/vga_plot_fifo_sync_fifo.sv
// sync_fifo: generic single-clock FIFO with registered occupancy count.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_push, i_wdata  write request / data (ignored when full)
//   i_pop, o_rdata   read request / head entry (ignored when empty)
//   o_empty, o_full  occupancy flags derived from the count register
//   o_count          number of stored entries (AW+1 bits)
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A full FIFO refuses a push even if a pop happens on the same edge.
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/vga_plot_fifo.sv
// vga_plot_fifo: clips engine pixel requests to the 160x120 screen, buffers
// the on-screen ones and drains them to the VGA adapter one per cycle.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid/in_ready               engine handshake (in_ready = ~full)
//   in_x[8:0], in_y[7:0]            signed coordinates; in_colour[2:0]
//   hold                            stalls draining, pushes continue
//   vga_x, vga_y, vga_colour        registered adapter write data
//   vga_plot                        one-cycle write strobe
//   empty, full                     FIFO occupancy flags
// Optional (VGA_PLOT_STATS_EN): clip_count, plot_count saturating counters.
module vga_plot_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] in_x,
  input  logic [7:0] in_y,
  input  logic [2:0] in_colour,
  input  logic       hold,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       empty,
  output logic       full
`ifdef VGA_PLOT_STATS_EN
  ,
  output logic [15:0] clip_count,
  output logic [15:0] plot_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic        w_accept;
  logic        w_on_screen;
  logic        w_push;
  logic        w_pop;
  pixel_t      w_in_pix;
  pixel_t      w_head;
  logic [AW:0] w_count;

  logic [7:0]  r_vga_x;
  logic [6:0]  r_vga_y;
  logic [2:0]  r_vga_colour;
  logic        r_vga_plot;

  assign in_ready    = (w_count != (AW+1)'(DEPTH));
  assign w_accept    = in_valid & in_ready;
  assign w_on_screen = on_screen(in_x, in_y);
  // Off-screen pixels complete the handshake but never enter the FIFO.
  assign w_push      = w_accept & w_on_screen;
  assign w_pop       = ~empty & ~hold;
  assign w_in_pix    = '{x: in_x[7:0], y: in_y[6:0], c: in_colour};

  sync_fifo #(
    .WIDTH ($bits(pixel_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_wdata (w_in_pix),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (empty),
    .o_full  (full),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
    end else if (w_pop) begin
      r_vga_x      <= w_head.x;
      r_vga_y      <= w_head.y;
      r_vga_colour <= w_head.c;
      r_vga_plot   <= 1'b1;
    end else begin
      r_vga_plot   <= 1'b0;
    end
  end

  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;

`ifdef VGA_PLOT_STATS_EN
  logic [15:0] r_clip_count;
  logic [15:0] r_plot_count;

  // plot_count steps on the edge that raises vga_plot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clip_count <= '0;
      r_plot_count <= '0;
    end else begin
      if (w_accept && !w_on_screen && r_clip_count != '1)
        r_clip_count <= r_clip_count + 16'd1;
      if (w_pop && r_plot_count != '1)
        r_plot_count <= r_plot_count + 16'd1;
    end
  end

  assign clip_count = r_clip_count;
  assign plot_count = r_plot_count;
`endif

endmodule

// File: tb/tb_vga_plot_fifo.sv
module tb_vga_plot_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_x = '0;
  logic [7:0] in_y = '0;
  logic [2:0] in_colour = '0;
  logic       hold = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       empty;
  logic       full;
`ifdef VGA_PLOT_STATS_EN
  logic [15:0] clip_count;
  logic [15:0] plot_count;
`endif

  vga_plot_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .hold       (hold),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .empty      (empty),
    .full       (full)
`ifdef VGA_PLOT_STATS_EN
    ,
    .clip_count (clip_count),
    .plot_count (plot_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending on-screen pixels plus the
  // last-written adapter values.
  typedef struct {
    int x;
    int y;
    int c;
  } pix_s;

  pix_s q[$];
  pix_s np;
  int   m_x = 0, m_y = 0, m_c = 0;
  bit   m_plot = 0;
  bit   m_live = 0;
  bit   m_was_full;
  int   m_clip = 0, m_pcnt = 0;
  int   sx, sy;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_x = 0; m_y = 0; m_c = 0; m_plot = 0;
      m_clip = 0; m_pcnt = 0;
      m_live = 1;
    end else begin
      m_was_full = (q.size() == DEPTH);
      if (q.size() != 0 && !hold) begin
        m_x = q[0].x; m_y = q[0].y; m_c = q[0].c;
        m_plot = 1;
        void'(q.pop_front());
        if (m_pcnt < 65535) m_pcnt++;
      end else begin
        m_plot = 0;
      end
      if (in_valid && !m_was_full) begin
        sx = int'($signed(in_x));
        sy = int'($signed(in_y));
        if (sx >= 0 && sx <= 159 && sy >= 0 && sy <= 119) begin
          np.x = sx; np.y = sy; np.c = int'(in_colour);
          q.push_back(np);
        end else if (m_clip < 65535) begin
          m_clip++;
        end
      end
    end
  end

  int pulses = 0;
  int lp_x = -1, lp_y = -1;

  always @(negedge clk) begin
    if (m_live) begin
      check("vga_plot", int'(vga_plot), int'(m_plot));
      check("vga_x", int'(vga_x), m_x);
      check("vga_y", int'(vga_y), m_y);
      check("vga_colour", int'(vga_colour), m_c);
      check("empty", int'(empty), int'(q.size() == 0));
      check("full", int'(full), int'(q.size() == DEPTH));
      check("in_ready", int'(in_ready), int'(q.size() != DEPTH));
`ifdef VGA_PLOT_STATS_EN
      check("clip_count", int'(clip_count), m_clip);
      check("plot_count", int'(plot_count), m_pcnt);
`endif
    end
    if (vga_plot) begin
      pulses++;
      lp_x = int'(vga_x);
      lp_y = int'(vga_y);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int x, input int y, input int c);
    in_valid  = 1'b1;
    in_x      = 9'(x);
    in_y      = 8'(y);
    in_colour = 3'(c);
  endtask

  int p0;
  int xs[5] = '{-1, 160, 5, 5, 159};
  int ys[5] = '{5, 5, 120, -3, 119};

  initial begin
    // Reset state
    tick();
    rst = 1'b0;
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_vga_x", int'(vga_x), 0);

    // Single pixel: strobe 2 cycles after acceptance
    drive(10, 20, 5);
    tick();
    in_valid = 1'b0;
    check("single_early", int'(vga_plot), 0);
    tick();
    check("single_plot", int'(vga_plot), 1);
    check("single_x", int'(vga_x), 10);
    check("single_y", int'(vga_y), 20);
    check("single_c", int'(vga_colour), 5);
    tick();
    check("single_plot_off", int'(vga_plot), 0);
    check("single_empty", int'(empty), 1);

    // Clipping
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      drive(xs[i], ys[i], i);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check("clip_pulses", pulses - p0, 1);
    check("clip_last_x", lp_x, 159);
    check("clip_last_y", lp_y, 119);
`ifdef VGA_PLOT_STATS_EN
    check("clip_count_lit", int'(clip_count), 4);
    check("plot_count_lit", int'(plot_count), 1);
`endif

    // Fill under hold, then release
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(i * 3, i, i % 8);
      tick();
      if (i == 14) check("fill_not_full_15", int'(full), 0);
      if (i == 15) check("fill_full_16", int'(full), 1);
    end
    in_valid = 1'b0;
    check("fill_full", int'(full), 1);
    check("fill_in_ready", int'(in_ready), 0);
    p0 = pulses;
    hold = 1'b0;
    tick();
    check("drain_in_ready", int'(in_ready), 1);
    check("drain_first_plot", int'(vga_plot), 1);
    check("drain_first_x", int'(vga_x), 0);
    repeat (17) tick();
    check("drain_pulses", pulses - p0, 16);
    check("drain_last_x", lp_x, 45);

    // Back-to-back stream
    p0 = pulses;
    for (int i = 0; i < 64; i++) begin
      drive(i + 50, i, i % 8);
      tick();
      if (i >= 2) check("stream_plot", int'(vga_plot), 1);
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("stream_pulses", pulses - p0, 64);
    check("stream_last_x", lp_x, 113);

    // Hold toggling during a burst
    p0 = pulses;
    for (int i = 0; i < 20; i++) begin
      hold = 1'(i % 2);
      if (i < 10) drive(100 + i, 100 + i, i % 8);
      else in_valid = 1'b0;
      tick();
    end
    hold = 1'b0;
    repeat (12) tick();
    check("toggle_pulses", pulses - p0, 10);
    check("toggle_last_x", lp_x, 109);

    // Reset with pixels buffered
    hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(i + 1, i + 1, 7);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_plot", int'(vga_plot), 0);
    check("midrst_empty", int'(empty), 1);
    check("midrst_in_ready", int'(in_ready), 1);
    hold = 1'b0;
    p0 = pulses;
    repeat (10) tick();
    check("midrst_no_stale", pulses - p0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      hold      = ((i / 40) % 3 == 0) ? ($urandom_range(0, 1) == 0)
                                      : ($urandom_range(0, 7) == 0);
      in_x      = 9'(int'($urandom_range(0, 175)) - 8);
      in_y      = 8'(int'($urandom_range(0, 135)) - 8);
      in_colour = 3'($urandom_range(0, 7));
      rst       = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    hold = 1'b0;
    repeat (DEPTH + 4) tick();
    check("final_empty", int'(empty), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_plot_fifo.md
Name: vga_plot_fifo

Overview:
- Buffers pixel-plot requests from the drawing engines (circle, Reuleaux triangle, fillscreen) and drives the VGA adapter plot port at one pixel per cycle.
- Sits directly downstream of the drawing engines and directly upstream of the 160x120, 3-bit-colour VGA adapter.
- Clips off-screen coordinates so engines can emit signed, unclipped points.
- Decouples engine stalls from adapter writes with a ready/valid input and a hold input on the drain side.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two and at least 2.
- AW, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clk  input  1  system clock, CLOCK_50 domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  engine presents a pixel.
- in_ready  output  1  block can accept a pixel this cycle.
- in_x  input  9  signed X coordinate, two's complement.
- in_y  input  8  signed Y coordinate, two's complement.
- in_colour  input  3  pixel colour.
- hold  input  1  stall the drain side; the FIFO keeps accepting pixels.
- vga_x  output  8  adapter X, 0..159.
- vga_y  output  7  adapter Y, 0..119.
- vga_colour  output  3  adapter colour.
- vga_plot  output  1  one-cycle write strobe to the adapter.
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds DEPTH entries.

Behaviour:
- Reset: synchronous, active-high, single state with no FSM beyond FIFO occupancy.
  - Pointers and count go to 0.
  - vga_x, vga_y, vga_colour and vga_plot go to 0; empty=1, full=0, in_ready=1 on the cycle after rst is sampled high.
  - Reset mid-operation discards all stored pixels; any pixel offered in the reset cycle is dropped.
- Handshake:
  - in_ready = ~full, combinational from the registered count.
  - A transfer occurs on a rising edge where in_valid & in_ready.
  - When in_ready=0, in_x, in_y and in_colour are ignored.
- Clipping:
  - A pixel is on-screen when 0 <= in_x <= 159 and 0 <= in_y <= 119, using a signed compare.
  - Off-screen pixels still complete the handshake but are not written, so count is unchanged.
  - On-screen pixels are stored truncated to 8-bit X and 7-bit Y.
- Drain:
  - On each edge where ~empty & ~hold, pop the head entry into the vga_x, vga_y and vga_colour registers and set vga_plot=1 for exactly one cycle.
  - Otherwise vga_plot=0, and vga_x, vga_y and vga_colour hold their last values.
- Latency: a pixel accepted at edge k into an empty FIFO shows vga_plot=1 in the cycle following edge k+1, i.e. 2 cycles. There is no input-to-output bypass.
- Throughput: 1 pixel/cycle sustained with hold=0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full: no push is accepted even if a pop happens in the same cycle.
- Pointer wrap: modulo DEPTH, with a separate count register of AW+1 bits. full = (count==DEPTH), empty = (count==0).
- hold asserted: no pops occur, and vga_plot drops on the next edge. Pushes continue until full.

Optional Feature:
- Macro: VGA_PLOT_STATS_EN.
- Defined:
  - Adds output clip_count, 16 bits: increments by 1 on every accepted off-screen pixel, saturates at 16'hFFFF, and resets to 0.
  - Adds output plot_count, 16 bits: increments on every vga_plot pulse, saturates at 16'hFFFF, and resets to 0.
- Undefined: neither port nor either counter exists. Core behaviour is identical in both builds.

Decomposition:
- vga_pkg holds:
  - constants SCREEN_W=160 and SCREEN_H=120;
  - typedefs colour_t (logic [2:0]), scr_x_t (logic [7:0]) and scr_y_t (logic [6:0]);
  - a packed struct pixel_t {scr_x_t x; scr_y_t y; colour_t c;}.
- One sub-module, sync_fifo:
  - parameterised by width and DEPTH, carries pixel_t;
  - provides push, pop, empty, full and count;
  - has no clipping or VGA knowledge.
- vga_plot_fifo contains the clipper, the output registers and the optional stats counters.

Test Plan:
- Reset then a single push of (x=10, y=20, colour=3'b101) with hold=0 -> vga_plot high exactly once, 2 cycles after acceptance, with vga_x=10, vga_y=20, vga_colour=5; empty=1 afterwards.
- Offer (-1,5), (160,5), (5,120) and (5,-3), then (159,119) -> only one vga_plot pulse, at (159,119). With VGA_PLOT_STATS_EN: clip_count=4 and plot_count=1.
- hold=1 while pushing 20 distinct pixels with DEPTH=16 -> full=1 and in_ready=0 after 16 accepts. Release hold -> 16 pulses in push order on consecutive cycles; in_ready returns 1 the cycle after the first pop.
- Continuous valid stream of 64 pixels with hold=0 -> 64 back-to-back vga_plot pulses, in order, with no gaps after the initial 2-cycle latency; count never exceeds 1.
- Toggle hold every other cycle during a 10-pixel burst -> no pulse while hold was sampled high, no pixel lost or duplicated, order preserved.
- Assert rst for one cycle with 8 pixels buffered -> vga_plot=0, empty=1 and in_ready=1 next cycle; no stale pixel is ever emitted afterwards.
